stream_xbar_mcast: RTL and testbench



---
 rtl/stream_xbar_mcast_pkg.sv | 22 ++
 rtl/stream_xbar_mcast_oup.sv | 97 +++++++++
 rtl/stream_xbar_mcast.sv | 88 ++++++++
 tb/tb_stream_xbar_mcast.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/stream_xbar_mcast_pkg.sv
// stream_xbar_mcast_pkg: width derivation, round-robin wrap and the default FIFO entry layout
package stream_xbar_mcast_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth > 0) ? $clog2(depth + 1) : 1;
    endfunction

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    // Entry layout for the default configuration; the sub-module re-declares it around payload_t
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  idx;
    } entry_default_t;

endpackage

// File: rtl/stream_xbar_mcast_oup.sv
// stream_xbar_mcast_oup: one output port - round-robin arbiter with lock-in feeding a FIFO
module stream_xbar_mcast_oup
    import stream_xbar_mcast_pkg::*;
#(
    parameter int unsigned NumInp    = 4,
    parameter int unsigned FifoDepth = 2,
    parameter type         payload_t = logic [31:0],
    parameter int unsigned IdxWidth  = idx_width(NumInp),
    parameter int unsigned CntWidth  = cnt_width(FifoDepth)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [NumInp-1:0]      req_i,
    input  payload_t [NumInp-1:0]  data_i,
    output logic [NumInp-1:0]      gnt_o,
    output payload_t               data_o,
    output logic [IdxWidth-1:0]    idx_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [CntWidth-1:0]    usage_o
);

    logic [IdxWidth-1:0] ptr_q, lock_idx_q, win, cand;
    logic                lock_q, found, can_acc;

    // A locked winner is kept regardless of the pointer until it is granted
    always_comb begin
        win   = lock_idx_q;
        found = lock_q;
        cand  = '0;
        for (int k = 0; k < int'(NumInp); k++) begin
            cand = IdxWidth'((int'(ptr_q) + k) % int'(NumInp));
            if (!found && req_i[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign gnt_o = (found && can_acc) ? (NumInp'(1) << win) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (found) begin
            lock_q     <= !can_acc;
            lock_idx_q <= win;
            if (can_acc) ptr_q <= IdxWidth'(rr_next(int'(win), NumInp));
        end
    end

    if (FifoDepth == 0) begin : g_pass
        assign can_acc = ready_i;
        assign valid_o = found;
        assign data_o  = data_i[win];
        assign idx_o   = win;
        assign usage_o = '0;
    end else begin : g_fifo
        localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
        typedef struct packed {
            payload_t            data;
            logic [IdxWidth-1:0] idx;
        } entry_t;
        entry_t              mem [FifoDepth];
        logic [PtrWidth-1:0] rd_q, wr_q;
        logic [CntWidth-1:0] cnt_q;
        logic                push, pop;

        assign pop     = valid_o && ready_i;
        assign can_acc = (cnt_q != CntWidth'(FifoDepth)) || pop;
        assign push    = found && can_acc;
        assign valid_o = cnt_q != '0;
        assign data_o  = valid_o ? mem[rd_q].data : '0;
        assign idx_o   = valid_o ? mem[rd_q].idx : '0;
        assign usage_o = cnt_q;

        always_ff @(posedge clk_i) begin
            if (push) mem[wr_q] <= '{data: data_i[win], idx: win};
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i || flush_i) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wr_q <= (wr_q == PtrWidth'(FifoDepth - 1)) ? '0 : wr_q + 1'b1;
                if (pop) rd_q <= (rd_q == PtrWidth'(FifoDepth - 1)) ? '0 : rd_q + 1'b1;
                cnt_q <= cnt_q + CntWidth'(push) - CntWidth'(pop);
            end
        end
    end

endmodule

// File: rtl/stream_xbar_mcast.sv
// stream_xbar_mcast: multicast stream crossbar with per-output arbitration and buffering.
// Define STREAM_XBAR_MCAST_STATS_EN to add per-output saturating stall counters.
module stream_xbar_mcast
    import stream_xbar_mcast_pkg::*;
#(
    parameter int unsigned NumInp    = 4,
    parameter int unsigned NumOut    = 4,
    parameter int unsigned DataWidth = 32,
    parameter type         payload_t = logic [DataWidth-1:0],
    parameter int unsigned FifoDepth = 2,
    parameter int unsigned IdxWidth  = idx_width(NumInp),
    parameter int unsigned CntWidth  = cnt_width(FifoDepth)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  payload_t [NumInp-1:0]              data_i,
    input  logic [NumInp-1:0][NumOut-1:0]      sel_i,
    input  logic [NumInp-1:0]                  valid_i,
    output logic [NumInp-1:0]                  ready_o,
    output payload_t [NumOut-1:0]              data_o,
    output logic [NumOut-1:0][IdxWidth-1:0]    idx_o,
    output logic [NumOut-1:0]                  valid_o,
    input  logic [NumOut-1:0]                  ready_i,
    output logic [NumOut-1:0][CntWidth-1:0]    usage_o
`ifdef STREAM_XBAR_MCAST_STATS_EN
    ,
    output logic [NumOut-1:0][31:0]            stall_cnt_o
`endif
);

    logic [NumInp-1:0][NumOut-1:0] sent_q, pend, gnt_row;
    logic [NumOut-1:0][NumInp-1:0] req_col, gnt_col;

    // An input retires once every still-pending destination is granted this cycle
    for (genvar i = 0; i < NumInp; i++) begin : g_in
        assign pend[i]    = sel_i[i] & ~sent_q[i];
        assign ready_o[i] = valid_i[i] && ((pend[i] & ~gnt_row[i]) == '0);
        for (genvar j = 0; j < NumOut; j++) begin : g_x
            assign req_col[j][i] = valid_i[i] && pend[i][j];
            assign gnt_row[i][j] = gnt_col[j][i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            sent_q <= '0;
        end else begin
            for (int i = 0; i < int'(NumInp); i++)
                sent_q[i] <= (valid_i[i] && ready_o[i]) ? '0 : (sent_q[i] | gnt_row[i]);
        end
    end

    for (genvar j = 0; j < NumOut; j++) begin : g_out
        stream_xbar_mcast_oup #(
            .NumInp    (NumInp),
            .FifoDepth (FifoDepth),
            .payload_t (payload_t),
            .IdxWidth  (IdxWidth),
            .CntWidth  (CntWidth)
        ) u_oup (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .req_i   (req_col[j]),
            .data_i  (data_i),
            .gnt_o   (gnt_col[j]),
            .data_o  (data_o[j]),
            .idx_o   (idx_o[j]),
            .valid_o (valid_o[j]),
            .ready_i (ready_i[j]),
            .usage_o (usage_o[j])
        );
    end

`ifdef STREAM_XBAR_MCAST_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            stall_cnt_o <= '0;
        end else begin
            for (int j = 0; j < int'(NumOut); j++)
                if (valid_o[j] && !ready_i[j] && stall_cnt_o[j] != '1)
                    stall_cnt_o[j] <= stall_cnt_o[j] + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_xbar_mcast.sv
// tb_stream_xbar_mcast: directed vector table plus reset/flush sequences for the 4x4, depth-2 crossbar
module tb_stream_xbar_mcast;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic [3:0][31:0] data_i;
    logic [3:0][3:0]  sel_i;
    logic [3:0]       valid_i;
    logic [3:0]       ready_o;
    logic [3:0][31:0] data_o;
    logic [3:0][1:0]  idx_o;
    logic [3:0]       valid_o;
    logic [3:0]       ready_i;
    logic [3:0][1:0]  usage_o;
`ifdef STREAM_XBAR_MCAST_STATS_EN
    logic [3:0][31:0] stall_cnt_o;
`endif

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    stream_xbar_mcast dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .data_i  (data_i),
        .sel_i   (sel_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .idx_o   (idx_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .usage_o (usage_o)
`ifdef STREAM_XBAR_MCAST_STATS_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    // sel packs {in3,in2,in1,in0}; din/e_dat are one byte per port, e_use/e_idx two bits per output
    typedef struct {
        logic [3:0]  v;
        logic [15:0] sel;
        logic [31:0] din;
        logic [3:0]  r;
        logic [3:0]  e_rdy;
        logic [3:0]  e_vld;
        logic [7:0]  e_use;
        logic [31:0] e_dat;
        logic [7:0]  e_idx;
    } vec_t;

    localparam int NV = 26;
    vec_t tv [NV];

    task automatic check(input string name, input int k, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s #%0d: got %0h expected %0h", name, k, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [15:0] s, input logic [31:0] d, input logic [3:0] r);
        valid_i = v;
        sel_i   = s;
        ready_i = r;
        for (int i = 0; i < 4; i++) data_i[i] = {24'h0, d[i*8+:8]};
    endtask

    initial begin
        logic [3:0][31:0] got_d, exp_d;
        logic [3:0][1:0]  got_i, exp_i;
        tv[0]  = '{4'b0001, 16'h0001, 32'h000000A5, 4'b1111, 4'b0001, 4'b0001, 8'h01, 32'h000000A5, 8'h00};
        tv[1]  = '{4'b0000, 16'h0000, 32'h00000000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 32'h00000000, 8'h00};
        tv[2]  = '{4'b0100, 16'h0400, 32'h00110000, 4'b1011, 4'b0100, 4'b0100, 8'h10, 32'h00110000, 8'h20};
        tv[3]  = '{4'b0100, 16'h0400, 32'h00120000, 4'b1011, 4'b0100, 4'b0100, 8'h20, 32'h00110000, 8'h20};
        tv[4]  = '{4'b0010, 16'h00F0, 32'h00003C00, 4'b1011, 4'b0000, 4'b1111, 8'h65, 32'h3C113C3C, 8'h65};
        tv[5]  = '{4'b0010, 16'h00F0, 32'h00003C00, 4'b1111, 4'b0010, 4'b0100, 8'h20, 32'h00120000, 8'h20};
        tv[6]  = '{4'b0000, 16'h0000, 32'h00000000, 4'b1111, 4'b0000, 4'b0100, 8'h10, 32'h003C0000, 8'h10};
        tv[7]  = '{4'b0000, 16'h0000, 32'h00000000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 32'h00000000, 8'h00};
        tv[8]  = '{4'b1111, 16'h1111, 32'h23222120, 4'b1111, 4'b0100, 4'b0001, 8'h01, 32'h00000022, 8'h02};
        tv[9]  = '{4'b1111, 16'h1111, 32'h23222120, 4'b1111, 4'b1000, 4'b0001, 8'h01, 32'h00000023, 8'h03};
        tv[10] = '{4'b1111, 16'h1111, 32'h23222120, 4'b1111, 4'b0001, 4'b0001, 8'h01, 32'h00000020, 8'h00};
        tv[11] = '{4'b1111, 16'h1111, 32'h23222120, 4'b1111, 4'b0010, 4'b0001, 8'h01, 32'h00000021, 8'h01};
        tv[12] = '{4'b1010, 16'h1111, 32'h23222120, 4'b1110, 4'b1000, 4'b0001, 8'h02, 32'h00000021, 8'h01};
        tv[13] = '{4'b1010, 16'h1111, 32'h23222120, 4'b1110, 4'b0000, 4'b0001, 8'h02, 32'h00000021, 8'h01};
        tv[14] = '{4'b1011, 16'h1111, 32'h23222120, 4'b1110, 4'b0000, 4'b0001, 8'h02, 32'h00000021, 8'h01};
        tv[15] = '{4'b1011, 16'h1111, 32'h23222120, 4'b1111, 4'b0010, 4'b0001, 8'h02, 32'h00000023, 8'h03};
        tv[16] = '{4'b1011, 16'h1111, 32'h23222120, 4'b1111, 4'b1000, 4'b0001, 8'h02, 32'h00000021, 8'h01};
        tv[17] = '{4'b0000, 16'h0000, 32'h00000000, 4'b1111, 4'b0000, 4'b0001, 8'h01, 32'h00000023, 8'h03};
        tv[18] = '{4'b0000, 16'h0000, 32'h00000000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 32'h00000000, 8'h00};
        tv[19] = '{4'b0100, 16'h0000, 32'h00000000, 4'b1111, 4'b0100, 4'b0000, 8'h00, 32'h00000000, 8'h00};
        tv[20] = '{4'b0001, 16'h0008, 32'h00000041, 4'b0111, 4'b0001, 4'b1000, 8'h40, 32'h41000000, 8'h00};
        tv[21] = '{4'b0001, 16'h0008, 32'h00000042, 4'b0111, 4'b0001, 4'b1000, 8'h80, 32'h41000000, 8'h00};
        tv[22] = '{4'b0001, 16'h0008, 32'h00000043, 4'b0111, 4'b0000, 4'b1000, 8'h80, 32'h41000000, 8'h00};
        tv[23] = '{4'b0001, 16'h0008, 32'h00000043, 4'b1111, 4'b0001, 4'b1000, 8'h80, 32'h42000000, 8'h00};
        tv[24] = '{4'b0000, 16'h0000, 32'h00000000, 4'b1111, 4'b0000, 4'b1000, 8'h40, 32'h43000000, 8'h00};
        tv[25] = '{4'b0000, 16'h0000, 32'h00000000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 32'h00000000, 8'h00};

        drive(4'b0000, 16'h0000, 32'h0, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_valid", 0, valid_o, 4'b0000);
        check("rst_usage", 0, usage_o, 8'h00);
        check("rst_data", 0, data_o, 128'h0);
        check("rst_idx", 0, idx_o, 8'h00);
        check("rst_ready", 0, ready_o, 4'b0000);

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(tv[k].v, tv[k].sel, tv[k].din, tv[k].r);
            #1;
            check("ready_o", k, ready_o, tv[k].e_rdy);
            @(posedge clk);
            #1;
            for (int j = 0; j < 4; j++) begin
                got_d[j] = tv[k].e_vld[j] ? data_o[j] : 32'h0;
                exp_d[j] = tv[k].e_vld[j] ? {24'h0, tv[k].e_dat[j*8+:8]} : 32'h0;
                got_i[j] = tv[k].e_vld[j] ? idx_o[j] : 2'd0;
                exp_i[j] = tv[k].e_vld[j] ? tv[k].e_idx[j*2+:2] : 2'd0;
            end
            check("valid_o", k, valid_o, tv[k].e_vld);
            check("usage_o", k, usage_o, tv[k].e_use);
            check("data_o", k, got_d, exp_d);
            check("idx_o", k, got_i, exp_i);
        end

        // Reset while a multicast beat sits in two output FIFOs
        @(negedge clk);
        drive(4'b0001, 16'h0003, 32'h00000055, 4'b0000);
        @(posedge clk);
        #1;
        check("mc_valid", 100, valid_o, 4'b0011);
        rst_i   = 1'b1;
        valid_i = 4'b0000;
        #1;
        check("arst_valid", 101, valid_o, 4'b0000);
        check("arst_usage", 101, usage_o, 8'h00);
        @(negedge clk);
        rst_i = 1'b0;

        // Advance out0's pointer, then flush: arbitration restarts at input 0
        @(negedge clk);
        drive(4'b0010, 16'h0010, 32'h00006600, 4'b0000);
        #1;
        check("pre_flush_ready", 102, ready_o, 4'b0010);
        @(posedge clk);
        @(negedge clk);
        drive(4'b0000, 16'h0000, 32'h0, 4'b0000);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        check("flush_valid", 103, valid_o, 4'b0000);
        check("flush_usage", 103, usage_o, 8'h00);
        @(negedge clk);
        flush_i = 1'b0;
        drive(4'b1111, 16'h1111, 32'h23222120, 4'b1111);
        #1;
        check("post_flush_ready", 104, ready_o, 4'b0001);
        @(posedge clk);
        #1;
        check("post_flush_idx", 104, idx_o[0], 2'd0);
        check("post_flush_data", 104, data_o[0], 32'h20);
        @(negedge clk);
        drive(4'b0000, 16'h0000, 32'h0, 4'b1111);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
